letc_core_decode: RTL and testbench
===================================

# letc_core_decode

Parametrised, pipelined RV32I decode stage for the LETC core, sitting between fetch and execute. It accepts one 32-bit instruction word plus PC per cycle over a valid/ready handshake and registers a fully decoded bundle: opcode, format, register indices, sign-extended immediate, rd write-enable and rd source. A two-entry main/skid buffer keeps `o_f_ready` registered so no combinational path runs from execute back to fetch. Flush support covers branch and trap redirects.

## Interface
- `PC_WIDTH`, 32: width of the PC carried alongside the instruction.
- `i_clk` in 1: core clock; all state updates on the rising edge.
- `i_rst_n` in 1: reset, asynchronous and active-low.
- `i_flush` in 1: discard all buffered entries and any same-cycle input.
- `i_f_valid` in 1: fetch presents an instruction.
- `o_f_ready` out 1: decode can accept; registered.
- `i_f_instr` in 32: instruction word.
- `i_f_pc` in PC_WIDTH: PC of `i_f_instr`.
- `o_d_valid` out 1: decoded bundle valid.
- `i_d_ready` in 1: execute consumes the bundle.
- `o_d_pc` out PC_WIDTH: PC of the bundle.
- `o_d_opcode` out 5 (`opcode_e`): instr[6:2].
- `o_d_format` out 3 (`instr_format_e`).
- `o_d_rd_src` out 2 (`rd_src_e`).
- `o_d_rd_idx`, `o_d_rs1_idx`, `o_d_rs2_idx` out 5 each: instr[11:7], [19:15], [24:20].
- `o_d_funct3` out 3, `o_d_funct7` out 7.
- `o_d_imm` out 32: immediate per format.
- `o_d_rd_we` out 1: rd is written.
- `o_d_illegal` out 1: illegal encoding (see Configuration).

## Operation
- Transfer in when `i_f_valid && o_f_ready`. Transfer out when `o_d_valid && i_d_ready`.
- Format:
  - LOAD, LOAD_FP, OP_IMM, JALR → I.
  - SYSTEM with funct3[2]=1 → UIMM; other SYSTEM → I.
  - STORE → S.
  - BRANCH → B.
  - LUI, AUIPC → U.
  - JAL → J.
  - All others → R.
- Immediate:
  - I: sext(instr[31:20]).
  - S: sext({instr[31:25], instr[11:7]}).
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U: {instr[31:12], 12'h0}.
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - UIMM: zext(instr[19:15]).
  - R: 0.
- rd_src:
  - LOAD → RD_FROM_MEM_LOAD.
  - JAL, JALR → RD_FROM_NEXT_SEQ_PC.
  - SYSTEM with funct3≠0 → RD_FROM_CSR.
  - Else → RD_FROM_ALU_RESULT.
- rd_we is 0 for STORE, BRANCH, MISC_MEM, SYSTEM with funct3=0, and whenever rd_idx=0. It is 1 otherwise.
- Buffer FSM, with flush taking precedence over every transition:
  - EMPTY: accept → FULL.
  - FULL, neither in nor out → FULL. Out only → EMPTY. In and out → FULL, main register replaced. In only → SKID, new entry written to the skid register.
  - SKID: `o_f_ready`=0. Out → FULL, skid entry moves to main. Else → SKID.
  - `i_flush` → EMPTY next cycle; same-cycle input is dropped.
- `o_f_ready` = (next state ≠ SKID), registered.

## Timing
- Latency: accepted in cycle N → `o_d_valid` in cycle N+1. Throughput: 1 instruction/cycle with `i_d_ready` held high.
- Reset values: `o_d_valid`=0, `o_f_ready`=1, all data outputs 0, FSM=EMPTY. Reset asserted mid-stream drops all entries immediately.
- Output bundle stays stable while `o_d_valid && !i_d_ready`.
- Fetch holds `i_f_instr`/`i_f_pc` stable until accepted.
- Order is strictly preserved; the skid entry is never overtaken.
- Flush with `i_d_ready`=1 in the same cycle: the current output still counts as consumed. `o_d_valid`=0 next cycle.

## Configuration
- `LETC_CORE_DECODE_ILLEGAL_CHECK_EN` defined:
  - `o_d_illegal`=1 when instr[1:0]≠2'b11, or when the opcode is outside {LOAD, MISC_MEM, OP_IMM, AUIPC, STORE, AMO, OP, LUI, BRANCH, JALR, JAL, SYSTEM}.
  - The flag is registered with the bundle; rd_we is forced to 0 when it is set.
- Macro undefined: `o_d_illegal` is tied to 0 and the check logic is absent.

## Structure
- `core_pkg` additions:
  - All opcode enumerators carry the `OPCODE_` prefix.
  - New `decoded_instr_s` packed struct holding every `o_d_*` field except valid and pc.
  - `imm_t`.
  - Function `sext_imm` for sign extension.
- Sub-module `letc_core_decode_comb`: purely combinational, instr → `decoded_instr_s`. Instantiated once, on the input side, so both buffer entries store already-decoded bundles.

## Test plan
- ADDI x1,x0,-1 (0xFFF00093), sink ready → cycle+1: opcode=OP_IMM, format=I, imm=0xFFFFFFFF, rd=1, rd_we=1, rd_src=ALU.
- Back-to-back SW/BEQ/JAL/LUI/CSRRWI at ready=1 → one bundle per cycle, in order. Each carries the correct S/B/J/U/UIMM imm. JAL has rd_src=NEXT_SEQ_PC; CSRRWI has rd_src=CSR.
- Sink stalls 3 cycles while source streams → exactly two entries held, `o_f_ready`=0 from the cycle after the skid fills; no loss or duplication on release.
- `i_flush` with both entries full plus input valid → next cycle `o_d_valid`=0, `o_f_ready`=1; the dropped instructions never appear.
- With the macro defined: word 0x0000_0013 with bits[1:0]=00 (i.e. 0x00000010) → illegal=1, rd_we=0. Opcode 5'b10101 → illegal=1. Macro undefined → illegal=0.
- Async reset asserted mid-stall → outputs return to reset values without a clock edge.

Source files
------------

// File: rtl/letc_core_decode_pkg.sv
// Shared types for the LETC RV32I decode stage: opcodes, formats, rd sources,
// the decoded bundle and the immediate sign-extension helper.
package letc_core_decode_pkg;

    localparam int unsigned INSTR_WIDTH = 32;
    localparam int unsigned IMM_WIDTH   = 32;
    localparam int unsigned REG_IDX_W   = 5;

    typedef logic [IMM_WIDTH-1:0] imm_t;

    // Major opcode, instr[6:2]
    typedef enum logic [4:0] {
        OPCODE_LOAD      = 5'b00000,
        OPCODE_LOAD_FP   = 5'b00001,
        OPCODE_CUSTOM_0  = 5'b00010,
        OPCODE_MISC_MEM  = 5'b00011,
        OPCODE_OP_IMM    = 5'b00100,
        OPCODE_AUIPC     = 5'b00101,
        OPCODE_OP_IMM_32 = 5'b00110,
        OPCODE_STORE     = 5'b01000,
        OPCODE_STORE_FP  = 5'b01001,
        OPCODE_CUSTOM_1  = 5'b01010,
        OPCODE_AMO       = 5'b01011,
        OPCODE_OP        = 5'b01100,
        OPCODE_LUI       = 5'b01101,
        OPCODE_OP_32     = 5'b01110,
        OPCODE_MADD      = 5'b10000,
        OPCODE_MSUB      = 5'b10001,
        OPCODE_NMSUB     = 5'b10010,
        OPCODE_NMADD     = 5'b10011,
        OPCODE_OP_FP     = 5'b10100,
        OPCODE_RESERVED_1 = 5'b10101,
        OPCODE_CUSTOM_2  = 5'b10110,
        OPCODE_BRANCH    = 5'b11000,
        OPCODE_JALR      = 5'b11001,
        OPCODE_RESERVED_2 = 5'b11010,
        OPCODE_JAL       = 5'b11011,
        OPCODE_SYSTEM    = 5'b11100,
        OPCODE_RESERVED_3 = 5'b11101,
        OPCODE_CUSTOM_3  = 5'b11110
    } opcode_e;

    typedef enum logic [2:0] {
        INSTR_FORMAT_R    = 3'd0,
        INSTR_FORMAT_I    = 3'd1,
        INSTR_FORMAT_S    = 3'd2,
        INSTR_FORMAT_B    = 3'd3,
        INSTR_FORMAT_U    = 3'd4,
        INSTR_FORMAT_J    = 3'd5,
        INSTR_FORMAT_UIMM = 3'd6
    } instr_format_e;

    typedef enum logic [1:0] {
        RD_FROM_ALU_RESULT  = 2'd0,
        RD_FROM_MEM_LOAD    = 2'd1,
        RD_FROM_NEXT_SEQ_PC = 2'd2,
        RD_FROM_CSR         = 2'd3
    } rd_src_e;

    typedef struct packed {
        opcode_e                opcode;
        instr_format_e          format;
        rd_src_e                rd_src;
        logic [REG_IDX_W-1:0]   rd_idx;
        logic [REG_IDX_W-1:0]   rs1_idx;
        logic [REG_IDX_W-1:0]   rs2_idx;
        logic [2:0]             funct3;
        logic [6:0]             funct7;
        imm_t                   imm;
        logic                   rd_we;
        logic                   illegal;
    } decoded_instr_s;

    // Replicate bit sign_bit of raw into every higher bit
    function automatic imm_t sext_imm(input imm_t raw, input int unsigned sign_bit);
        imm_t w_shl;
        w_shl = raw << (IMM_WIDTH - 1 - sign_bit);
        return imm_t'($signed(w_shl) >>> (IMM_WIDTH - 1 - sign_bit));
    endfunction

endpackage

// File: rtl/letc_core_decode_comb.sv
// Purely combinational RV32I instruction decoder: instruction word -> decoded bundle.
// Optional illegal-encoding check enabled by LETC_CORE_DECODE_ILLEGAL_CHECK_EN.
module letc_core_decode_comb
    import letc_core_decode_pkg::*;
(
    input  logic [INSTR_WIDTH-1:0] i_instr,
    output decoded_instr_s         o_decoded
);

    opcode_e        w_opcode;
    logic [2:0]     w_funct3;
    logic [4:0]     w_rd_idx;
    instr_format_e  w_format;
    imm_t           w_imm;
    rd_src_e        w_rd_src;
    logic           w_rd_we_base;
    logic           w_illegal;

    assign w_opcode = opcode_e'(i_instr[6:2]);
    assign w_funct3 = i_instr[14:12];
    assign w_rd_idx = i_instr[11:7];

    // Instruction format from the major opcode
    always_comb begin
        w_format = INSTR_FORMAT_R;
        case (w_opcode)
            OPCODE_LOAD, OPCODE_LOAD_FP, OPCODE_OP_IMM, OPCODE_JALR:
                w_format = INSTR_FORMAT_I;
            OPCODE_SYSTEM:
                w_format = w_funct3[2] ? INSTR_FORMAT_UIMM : INSTR_FORMAT_I;
            OPCODE_STORE:
                w_format = INSTR_FORMAT_S;
            OPCODE_BRANCH:
                w_format = INSTR_FORMAT_B;
            OPCODE_LUI, OPCODE_AUIPC:
                w_format = INSTR_FORMAT_U;
            OPCODE_JAL:
                w_format = INSTR_FORMAT_J;
            default:
                w_format = INSTR_FORMAT_R;
        endcase
    end

    // Immediate assembly per format
    always_comb begin
        w_imm = '0;
        case (w_format)
            INSTR_FORMAT_I:
                w_imm = sext_imm(imm_t'(i_instr[31:20]), 11);
            INSTR_FORMAT_S:
                w_imm = sext_imm(imm_t'({i_instr[31:25], i_instr[11:7]}), 11);
            INSTR_FORMAT_B:
                w_imm = sext_imm(imm_t'({i_instr[31], i_instr[7], i_instr[30:25],
                                         i_instr[11:8], 1'b0}), 12);
            INSTR_FORMAT_U:
                w_imm = {i_instr[31:12], 12'h000};
            INSTR_FORMAT_J:
                w_imm = sext_imm(imm_t'({i_instr[31], i_instr[19:12], i_instr[20],
                                         i_instr[30:21], 1'b0}), 20);
            INSTR_FORMAT_UIMM:
                w_imm = imm_t'(i_instr[19:15]);
            default:
                w_imm = '0;
        endcase
    end

    // Where the rd write data comes from, and whether the opcode writes rd at all
    always_comb begin
        w_rd_src     = RD_FROM_ALU_RESULT;
        w_rd_we_base = 1'b1;
        case (w_opcode)
            OPCODE_LOAD:
                w_rd_src = RD_FROM_MEM_LOAD;
            OPCODE_JAL, OPCODE_JALR:
                w_rd_src = RD_FROM_NEXT_SEQ_PC;
            OPCODE_SYSTEM: begin
                if (w_funct3 != 3'd0) begin
                    w_rd_src = RD_FROM_CSR;
                end else begin
                    w_rd_we_base = 1'b0;
                end
            end
            OPCODE_STORE, OPCODE_BRANCH, OPCODE_MISC_MEM:
                w_rd_we_base = 1'b0;
            default: begin
                w_rd_src     = RD_FROM_ALU_RESULT;
                w_rd_we_base = 1'b1;
            end
        endcase
    end

`ifdef LETC_CORE_DECODE_ILLEGAL_CHECK_EN
    logic w_legal_opcode;

    // Opcodes this core implements
    always_comb begin
        w_legal_opcode = 1'b0;
        case (w_opcode)
            OPCODE_LOAD, OPCODE_MISC_MEM, OPCODE_OP_IMM, OPCODE_AUIPC,
            OPCODE_STORE, OPCODE_AMO, OPCODE_OP, OPCODE_LUI,
            OPCODE_BRANCH, OPCODE_JALR, OPCODE_JAL, OPCODE_SYSTEM:
                w_legal_opcode = 1'b1;
            default:
                w_legal_opcode = 1'b0;
        endcase
    end

    assign w_illegal = (i_instr[1:0] != 2'b11) || !w_legal_opcode;
`else
    // Length bits are only inspected by the illegal check
    logic [1:0] w_unused_lsbs;
    assign w_unused_lsbs = i_instr[1:0];
    assign w_illegal     = 1'b0;
`endif

    // Pack the bundle; an illegal encoding never writes rd
    always_comb begin
        o_decoded         = '0;
        o_decoded.opcode  = w_opcode;
        o_decoded.format  = w_format;
        o_decoded.rd_src  = w_rd_src;
        o_decoded.rd_idx  = w_rd_idx;
        o_decoded.rs1_idx = i_instr[19:15];
        o_decoded.rs2_idx = i_instr[24:20];
        o_decoded.funct3  = w_funct3;
        o_decoded.funct7  = i_instr[31:25];
        o_decoded.imm     = w_imm;
        o_decoded.rd_we   = w_rd_we_base && (w_rd_idx != 5'd0) && !w_illegal;
        o_decoded.illegal = w_illegal;
    end

endmodule

// File: rtl/letc_core_decode.sv
// LETC core decode stage: decodes on the input side and holds results in a
// main/skid register pair so o_f_ready is a flop. Optional illegal-encoding
// flag controlled by LETC_CORE_DECODE_ILLEGAL_CHECK_EN.
module letc_core_decode
    import letc_core_decode_pkg::*;
#(
    parameter int unsigned PC_WIDTH = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_flush,
    input  logic                   i_f_valid,
    output logic                   o_f_ready,
    input  logic [INSTR_WIDTH-1:0] i_f_instr,
    input  logic [PC_WIDTH-1:0]    i_f_pc,
    output logic                   o_d_valid,
    input  logic                   i_d_ready,
    output logic [PC_WIDTH-1:0]    o_d_pc,
    output opcode_e                o_d_opcode,
    output instr_format_e          o_d_format,
    output rd_src_e                o_d_rd_src,
    output logic [REG_IDX_W-1:0]   o_d_rd_idx,
    output logic [REG_IDX_W-1:0]   o_d_rs1_idx,
    output logic [REG_IDX_W-1:0]   o_d_rs2_idx,
    output logic [2:0]             o_d_funct3,
    output logic [6:0]             o_d_funct7,
    output imm_t                   o_d_imm,
    output logic                   o_d_rd_we,
    output logic                   o_d_illegal
);

    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_FULL  = 2'b01;
    localparam logic [1:0] ST_SKID  = 2'b10;

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic                r_f_ready;
    logic                r_d_valid;
    decoded_instr_s      w_dec;
    decoded_instr_s      r_main;
    decoded_instr_s      r_skid;
    logic [PC_WIDTH-1:0] r_main_pc;
    logic [PC_WIDTH-1:0] r_skid_pc;
    logic                w_in;
    logic                w_out;
    logic                w_load_main_in;
    logic                w_load_main_skid;
    logic                w_load_skid;

    letc_core_decode_comb u_comb (
        .i_instr   (i_f_instr),
        .o_decoded (w_dec)
    );

    assign w_in  = i_f_valid && r_f_ready;
    assign w_out = r_d_valid && i_d_ready;

    // Buffer next-state and register load enables; flush overrides everything
    always_comb begin
        w_state_next     = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (i_flush) begin
            w_state_next = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in) begin
                        w_state_next   = ST_FULL;
                        w_load_main_in = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (w_in && w_out) begin
                        w_load_main_in = 1'b1;
                    end else if (w_in) begin
                        w_state_next = ST_SKID;
                        w_load_skid  = 1'b1;
                    end else if (w_out) begin
                        w_state_next = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (w_out) begin
                        w_state_next     = ST_FULL;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: begin
                    w_state_next = ST_EMPTY;
                end
            endcase
        end
    end

    // State register plus registered handshake outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_EMPTY;
            r_f_ready <= 1'b1;
            r_d_valid <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_f_ready <= (w_state_next != ST_SKID);
            r_d_valid <= (w_state_next != ST_EMPTY);
        end
    end

    // Main (output) entry: new input or promoted skid entry
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_main    <= '0;
            r_main_pc <= '0;
        end else if (w_load_main_in) begin
            r_main    <= w_dec;
            r_main_pc <= i_f_pc;
        end else if (w_load_main_skid) begin
            r_main    <= r_skid;
            r_main_pc <= r_skid_pc;
        end
    end

    // Skid entry: catches the input arriving while the output is stalled
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_skid    <= '0;
            r_skid_pc <= '0;
        end else if (w_load_skid) begin
            r_skid    <= w_dec;
            r_skid_pc <= i_f_pc;
        end
    end

    assign o_f_ready   = r_f_ready;
    assign o_d_valid   = r_d_valid;
    assign o_d_pc      = r_main_pc;
    assign o_d_opcode  = r_main.opcode;
    assign o_d_format  = r_main.format;
    assign o_d_rd_src  = r_main.rd_src;
    assign o_d_rd_idx  = r_main.rd_idx;
    assign o_d_rs1_idx = r_main.rs1_idx;
    assign o_d_rs2_idx = r_main.rs2_idx;
    assign o_d_funct3  = r_main.funct3;
    assign o_d_funct7  = r_main.funct7;
    assign o_d_imm     = r_main.imm;
    assign o_d_rd_we   = r_main.rd_we;
    assign o_d_illegal = r_main.illegal;

endmodule

// File: tb/tb_letc_core_decode.sv
// Self-checking bench for letc_core_decode: table of decoded vectors streamed
// at full rate, then stall, flush and asynchronous-reset sequences.
module tb_letc_core_decode;
    import letc_core_decode_pkg::*;

`ifdef LETC_CORE_DECODE_ILLEGAL_CHECK_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        f_valid;
    logic        f_ready;
    logic [31:0] f_instr;
    logic [31:0] f_pc;
    logic        d_valid;
    logic        d_ready;
    logic [31:0] d_pc;
    logic [4:0]  d_opcode;
    logic [2:0]  d_format;
    logic [1:0]  d_rd_src;
    logic [4:0]  d_rd_idx;
    logic [4:0]  d_rs1_idx;
    logic [4:0]  d_rs2_idx;
    logic [2:0]  d_funct3;
    logic [6:0]  d_funct7;
    logic [31:0] d_imm;
    logic        d_rd_we;
    logic        d_illegal;

    int n_cmp;
    int n_bad;

    letc_core_decode #(.PC_WIDTH(32)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_flush     (flush),
        .i_f_valid   (f_valid),
        .o_f_ready   (f_ready),
        .i_f_instr   (f_instr),
        .i_f_pc      (f_pc),
        .o_d_valid   (d_valid),
        .i_d_ready   (d_ready),
        .o_d_pc      (d_pc),
        .o_d_opcode  (d_opcode),
        .o_d_format  (d_format),
        .o_d_rd_src  (d_rd_src),
        .o_d_rd_idx  (d_rd_idx),
        .o_d_rs1_idx (d_rs1_idx),
        .o_d_rs2_idx (d_rs2_idx),
        .o_d_funct3  (d_funct3),
        .o_d_funct7  (d_funct7),
        .o_d_imm     (d_imm),
        .o_d_rd_we   (d_rd_we),
        .o_d_illegal (d_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  opc;
        logic [2:0]  fmt;
        logic [1:0]  src;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        we;    // rd write-enable ignoring the illegal check
        logic        bad;   // encoding the illegal check must flag
    } vec_t;

    localparam int NV = 15;
    vec_t vec [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_bundle(input string name, input vec_t v, input logic [31:0] pc);
        logic exp_ill;
        exp_ill = ILL_EN && v.bad;
        chk($sformatf("%s.valid", name),   64'(d_valid),   64'(1'b1));
        chk($sformatf("%s.pc", name),      64'(d_pc),      64'(pc));
        chk($sformatf("%s.opcode", name),  64'(d_opcode),  64'(v.opc));
        chk($sformatf("%s.format", name),  64'(d_format),  64'(v.fmt));
        chk($sformatf("%s.rd_src", name),  64'(d_rd_src),  64'(v.src));
        chk($sformatf("%s.rd", name),      64'(d_rd_idx),  64'(v.rd));
        chk($sformatf("%s.rs1", name),     64'(d_rs1_idx), 64'(v.rs1));
        chk($sformatf("%s.rs2", name),     64'(d_rs2_idx), 64'(v.rs2));
        chk($sformatf("%s.funct3", name),  64'(d_funct3),  64'(v.f3));
        chk($sformatf("%s.funct7", name),  64'(d_funct7),  64'(v.f7));
        chk($sformatf("%s.imm", name),     64'(d_imm),     64'(v.imm));
        chk($sformatf("%s.rd_we", name),   64'(d_rd_we),   64'(v.we && !exp_ill));
        chk($sformatf("%s.illegal", name), 64'(d_illegal), 64'(exp_ill));
    endtask

    task automatic drive(input vec_t v, input logic [31:0] pc);
        f_valid = 1'b1;
        f_instr = v.instr;
        f_pc    = pc;
    endtask

    task automatic check_reset_vals(input string name);
        chk($sformatf("%s.valid", name),   64'(d_valid),   64'(1'b0));
        chk($sformatf("%s.f_ready", name), 64'(f_ready),   64'(1'b1));
        chk($sformatf("%s.pc", name),      64'(d_pc),      64'(0));
        chk($sformatf("%s.imm", name),     64'(d_imm),     64'(0));
        chk($sformatf("%s.opcode", name),  64'(d_opcode),  64'(0));
        chk($sformatf("%s.rd", name),      64'(d_rd_idx),  64'(0));
        chk($sformatf("%s.rd_we", name),   64'(d_rd_we),   64'(0));
        chk($sformatf("%s.illegal", name), 64'(d_illegal), 64'(0));
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        //        instr         opc       fmt                src                  rd  rs1 rs2 f3  f7     imm           we  bad
        vec[0]  = '{32'hFFF00093, 5'b00100, INSTR_FORMAT_I,    RD_FROM_ALU_RESULT,  1,  0, 31, 0, 7'h7F, 32'hFFFFFFFF, 1, 0}; // addi x1,x0,-1
        vec[1]  = '{32'hFE20AE23, 5'b01000, INSTR_FORMAT_S,    RD_FROM_ALU_RESULT,  28, 1, 2,  2, 7'h7F, 32'hFFFFFFFC, 0, 0}; // sw x2,-4(x1)
        vec[2]  = '{32'hFE208CE3, 5'b11000, INSTR_FORMAT_B,    RD_FROM_ALU_RESULT,  25, 1, 2,  0, 7'h7F, 32'hFFFFFFF8, 0, 0}; // beq x1,x2,-8
        vec[3]  = '{32'h001000EF, 5'b11011, INSTR_FORMAT_J,    RD_FROM_NEXT_SEQ_PC, 1,  0, 1,  0, 7'h00, 32'h00000800, 1, 0}; // jal x1,+2048
        vec[4]  = '{32'h123452B7, 5'b01101, INSTR_FORMAT_U,    RD_FROM_ALU_RESULT,  5,  8, 3,  5, 7'h09, 32'h12345000, 1, 0}; // lui x5,0x12345
        vec[5]  = '{32'h305AD1F3, 5'b11100, INSTR_FORMAT_UIMM, RD_FROM_CSR,         3, 21, 5,  5, 7'h18, 32'h00000015, 1, 0}; // csrrwi x3,mtvec,21
        vec[6]  = '{32'h00000073, 5'b11100, INSTR_FORMAT_I,    RD_FROM_ALU_RESULT,  0,  0, 0,  0, 7'h00, 32'h00000000, 0, 0}; // ecall
        vec[7]  = '{32'h00412003, 5'b00000, INSTR_FORMAT_I,    RD_FROM_MEM_LOAD,    0,  2, 4,  2, 7'h00, 32'h00000004, 0, 0}; // lw x0,4(x2)
        vec[8]  = '{32'h00C58533, 5'b01100, INSTR_FORMAT_R,    RD_FROM_ALU_RESULT,  10, 11, 12, 0, 7'h00, 32'h00000000, 1, 0}; // add x10,x11,x12
        vec[9]  = '{32'hFFFFF097, 5'b00101, INSTR_FORMAT_U,    RD_FROM_ALU_RESULT,  1, 31, 31, 7, 7'h7F, 32'hFFFFF000, 1, 0}; // auipc x1,0xfffff
        vec[10] = '{32'h800280E7, 5'b11001, INSTR_FORMAT_I,    RD_FROM_NEXT_SEQ_PC, 1,  5, 0,  0, 7'h40, 32'hFFFFF800, 1, 0}; // jalr x1,-2048(x5)
        vec[11] = '{32'h0FF0000F, 5'b00011, INSTR_FORMAT_R,    RD_FROM_ALU_RESULT,  0,  0, 31, 0, 7'h07, 32'h00000000, 0, 0}; // fence
        vec[12] = '{32'h30002273, 5'b11100, INSTR_FORMAT_I,    RD_FROM_CSR,         4,  0, 0,  2, 7'h18, 32'h00000300, 1, 0}; // csrrs x4,mstatus,x0
        vec[13] = '{32'h00000010, 5'b00100, INSTR_FORMAT_I,    RD_FROM_ALU_RESULT,  0,  0, 0,  0, 7'h00, 32'h00000000, 0, 1}; // bits[1:0]=00
        vec[14] = '{32'h000000D7, 5'b10101, INSTR_FORMAT_R,    RD_FROM_ALU_RESULT,  1,  0, 0,  0, 7'h00, 32'h00000000, 1, 1}; // reserved opcode

        rst_n   = 1'b0;
        flush   = 1'b0;
        f_valid = 1'b0;
        f_instr = '0;
        f_pc    = '0;
        d_ready = 1'b0;

        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;

        // Full-rate stream: each vector driven one cycle, checked the next
        d_ready = 1'b1;
        for (int i = 0; i <= NV; i++) begin
            if (i > 0) begin
                check_bundle($sformatf("vec%0d", i - 1), vec[i - 1], 32'h1000 + 32'(4 * (i - 1)));
                chk($sformatf("vec%0d.f_ready", i - 1), 64'(f_ready), 64'(1'b1));
            end
            if (i < NV) drive(vec[i], 32'h1000 + 32'(4 * i));
            else f_valid = 1'b0;
            @(negedge clk);
        end
        chk("stream.drain_valid", 64'(d_valid), 64'(1'b0));

        // Sink stalls while source streams: main and skid fill, ready drops
        d_ready = 1'b0;
        drive(vec[1], 32'h2000);
        @(negedge clk);
        check_bundle("stallA0", vec[1], 32'h2000);
        chk("stallA0.f_ready", 64'(f_ready), 64'(1'b1));
        drive(vec[2], 32'h2004);
        @(negedge clk);
        check_bundle("stallA1", vec[1], 32'h2000);
        chk("stallA1.f_ready", 64'(f_ready), 64'(1'b0));
        drive(vec[3], 32'h2008);
        @(negedge clk);
        check_bundle("stallA2", vec[1], 32'h2000);
        chk("stallA2.f_ready", 64'(f_ready), 64'(1'b0));
        @(negedge clk);
        check_bundle("stallA3", vec[1], 32'h2000);
        chk("stallA3.f_ready", 64'(f_ready), 64'(1'b0));
        d_ready = 1'b1;
        @(negedge clk);
        check_bundle("stallB", vec[2], 32'h2004);
        chk("stallB.f_ready", 64'(f_ready), 64'(1'b1));
        @(negedge clk);
        check_bundle("stallC", vec[3], 32'h2008);
        f_valid = 1'b0;
        @(negedge clk);
        chk("stall.drain_valid", 64'(d_valid), 64'(1'b0));

        // Flush with both entries occupied and a new input presented
        d_ready = 1'b0;
        drive(vec[4], 32'h3000);
        @(negedge clk);
        drive(vec[5], 32'h3004);
        @(negedge clk);
        chk("flush.pre_f_ready", 64'(f_ready), 64'(1'b0));
        drive(vec[6], 32'h3008);
        flush = 1'b1;
        @(negedge clk);
        flush   = 1'b0;
        f_valid = 1'b0;
        chk("flush.valid", 64'(d_valid), 64'(1'b0));
        chk("flush.f_ready", 64'(f_ready), 64'(1'b1));
        @(negedge clk);
        chk("flush.quiet1", 64'(d_valid), 64'(1'b0));
        d_ready = 1'b1;
        drive(vec[8], 32'h3010);
        @(negedge clk);
        check_bundle("flush.next", vec[8], 32'h3010);
        f_valid = 1'b0;

        // Flush in FULL while the sink consumes and fetch offers a new word
        drive(vec[9], 32'h4000);
        @(negedge clk);
        check_bundle("flush2.pre", vec[9], 32'h4000);
        drive(vec[10], 32'h4004);
        flush = 1'b1;
        @(negedge clk);
        flush   = 1'b0;
        f_valid = 1'b0;
        chk("flush2.valid", 64'(d_valid), 64'(1'b0));
        chk("flush2.f_ready", 64'(f_ready), 64'(1'b1));
        @(negedge clk);
        chk("flush2.quiet", 64'(d_valid), 64'(1'b0));

        // Asynchronous reset while stalled with the skid full
        d_ready = 1'b0;
        drive(vec[0], 32'h5000);
        @(negedge clk);
        drive(vec[4], 32'h5004);
        @(negedge clk);
        chk("areset.pre_f_ready", 64'(f_ready), 64'(1'b0));
        chk("areset.pre_valid", 64'(d_valid), 64'(1'b1));
        f_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("areset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("areset.post_valid", 64'(d_valid), 64'(1'b0));
        chk("areset.post_f_ready", 64'(f_ready), 64'(1'b1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
